cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
Run/debug sequencer for the 8-bit CPU core. It owns the core's reset and clock-enable, and it accepts host commands: RUN, STEP, HALT and RESTART.
It stops the core on a PC breakpoint or on a decoded HALT instruction. It also keeps a count of cycles in which the core advanced.
It sits between the board-level host interface (buttons or UART command decoder) and the cpu top level.

Parameters:
PC_W, 8, width of PC / breakpoint address
CYC_W, 16, width of executed-cycle counter
RST_CYCLES, 2, cycles CPU_RST is held after entering the reset sequence (>=1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
CMD_VALID  in  1  host command strobe
CMD  in  2  0=RUN, 1=STEP, 2=HALT, 3=RESTART
CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY
BP_EN  in  1  breakpoint enable
BP_ADDR  in  PC_W  breakpoint PC value
PC  in  PC_W  current PC from core
HALT_INST  in  1  core decoder HALT flag for instruction at PC
CPU_RST  out  1  synchronous reset to core
CPU_CE  out  1  core clock enable; core state advances only when 1
EN_L  out  1  halt-honour enable to core; constant 1 outside reset
STATE  out  3  current state encoding (debug)
CYC_CNT  out  CYC_W  CE-cycles executed since last restart, saturating
BP_HIT  out  1  sticky: stopped on breakpoint
DONE  out  1  sticky: stopped on HALT instruction

Behaviour:
- RESET asserted (async): STATE=RSTSEQ, CPU_RST=1, CPU_CE=1, EN_L=0, CMD_READY=0, CYC_CNT=0, BP_HIT=0, DONE=0, rst counter=0.
- States: RSTSEQ, HALTED, RUN, STEP.
- RSTSEQ:
  - CPU_RST=1, CPU_CE=1, CMD_READY=0.
  - Stays for RST_CYCLES clocks, then goes to HALTED with CPU_RST=0.
  - Commands are not accepted.
- HALTED:
  - CPU_CE=0, CMD_READY=1.
  - RUN: goes to RUN, sets skip flag, clears BP_HIT.
  - STEP: goes to STEP, clears BP_HIT.
  - HALT: no-op.
  - RESTART: goes to RSTSEQ; clears CYC_CNT, DONE, BP_HIT.
- RUN:
  - CPU_CE is combinational: 1 unless (BP_EN & PC==BP_ADDR & !skip), or HALT_INST.
  - skip clears after the first RUN cycle, so resuming at a breakpoint executes that instruction.
  - Breakpoint match (not skipped): CE=0 that cycle, BP_HIT<=1, next state HALTED.
  - HALT_INST: CE=0, DONE<=1, next state HALTED.
  - HALT command accepted: CE stays 1 in the accepting cycle, next state HALTED.
  - RESTART command: goes to RSTSEQ with the same clears as in HALTED.
  - RUN/STEP commands: accepted and ignored.
  - Priority within one cycle: RESTART > breakpoint > HALT_INST > HALT command.
- STEP:
  - CPU_CE=1 for exactly one cycle regardless of breakpoint, then goes to HALTED.
  - If HALT_INST is asserted in the STEP cycle, DONE<=1.
  - CMD_READY=0 in STEP.
- CYC_CNT:
  - Increments on every clock with CPU_CE=1 and STATE!=RSTSEQ.
  - Saturates at 2^CYC_W-1; never wraps.
- EN_L=1 in all states except RSTSEQ.
- DONE and BP_HIT are sticky until the clears listed above.
- RESET asserted mid-RUN/STEP overrides everything immediately.
- CMD_VALID without CMD_READY: the command is dropped; the host must hold it.

Decomposition:
- Package cpu_ctrl_pkg: state encoding constants (RSTSEQ=0, HALTED=1, RUN=2, STEP=3), CMD codes, default widths.
- One natural sub-module: sat_counter (parameterised width, enable, synchronous clear, async reset) for CYC_CNT and the reset-sequence counter.

Test Plan:
- Reset release with RST_CYCLES=2 -> CPU_RST high for 2 clocks after RESET falls, then STATE=HALTED, CPU_CE=0, CMD_READY=1, CYC_CNT=0.
- RUN, BP_EN=1, BP_ADDR=0x06, PC sequence 0,2,4,6 -> CE=1 for 3 cycles, CE=0 at PC=0x06, BP_HIT=1, CYC_CNT=3, STATE=HALTED.
- RUN again from PC=0x06 -> first cycle CE=1 (skip works), BP_HIT cleared, continues running.
- STEP issued 3 times from HALTED -> exactly 3 CE pulses, each 1 cycle wide; CYC_CNT increases by 3.
- HALT_INST=1 at PC=0x10 during RUN -> CE=0 that cycle, DONE=1, STATE=HALTED; subsequent RESTART clears DONE and CYC_CNT and re-enters RSTSEQ.
- CYC_W=4, RUN 20 cycles -> CYC_CNT saturates at 15; RESET asserted mid-RUN -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the CPU run/debug sequencer: state codes, host command
// codes and default widths.
package cpu_ctrl_pkg;

  localparam int PC_W_DEF       = 8;
  localparam int CYC_W_DEF      = 16;
  localparam int RST_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_RSTSEQ = 3'd0,
    ST_HALTED = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_RUN     = 2'd0,
    CMD_STEP    = 2'd1,
    CMD_HALT    = 2'd2,
    CMD_RESTART = 2'd3
  } cmd_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/debug sequencer: owns the core's reset and clock-enable, takes host
// RUN/STEP/HALT/RESTART commands and stops on breakpoints or HALT instructions.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W       = PC_W_DEF,
  parameter int CYC_W      = CYC_W_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  // Command handshake: a command takes effect only on a cycle where
  // CMD_VALID & CMD_READY; otherwise it is dropped and the host must hold it.
  input  logic             CMD_VALID,
  input  logic [1:0]       CMD,
  output logic             CMD_READY,
  input  logic             BP_EN,
  input  logic [PC_W-1:0]  BP_ADDR,
  input  logic [PC_W-1:0]  PC,
  input  logic             HALT_INST,
  output logic             CPU_RST,
  output logic             CPU_CE,
  output logic             EN_L,
  output logic [2:0]       STATE,
  output logic [CYC_W-1:0] CYC_CNT,
  output logic             BP_HIT,
  output logic             DONE
);

  localparam int RST_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  state_e state_q, state_d;
  logic   skip_q, skip_d;
  logic   bp_hit_q, bp_hit_d;
  logic   done_q, done_d;

  logic             cmd_ready;
  logic             cpu_ce;
  logic             cyc_clr;
  logic             cmd_fire;
  logic             bp_match;
  cmd_e             cmd;
  logic [RST_W-1:0] rst_cnt;
  logic [CYC_W-1:0] cyc_cnt;

  assign cmd      = cmd_e'(CMD);
  assign cmd_fire = CMD_VALID && cmd_ready;
  // skip suppresses the breakpoint on the first RUN cycle so a resume at
  // the breakpoint PC executes that instruction.
  assign bp_match = BP_EN && (PC == BP_ADDR) && !skip_q;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    bp_hit_d  = bp_hit_q;
    done_d    = done_q;
    cmd_ready = 1'b0;
    cpu_ce    = 1'b0;
    cyc_clr   = 1'b0;
    case (state_q)
      ST_RSTSEQ: begin
        cpu_ce = 1'b1;
        if (rst_cnt == RST_LAST) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        cmd_ready = 1'b1;
        if (cmd_fire) begin
          case (cmd)
            CMD_RUN: begin
              state_d  = ST_RUN;
              skip_d   = 1'b1;
              bp_hit_d = 1'b0;
            end
            CMD_STEP: begin
              state_d  = ST_STEP;
              bp_hit_d = 1'b0;
            end
            CMD_RESTART: begin
              state_d  = ST_RSTSEQ;
              cyc_clr  = 1'b1;
              done_d   = 1'b0;
              bp_hit_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cmd_ready = 1'b1;
        cpu_ce    = !(bp_match || HALT_INST);
        skip_d    = 1'b0;
        if (cmd_fire && (cmd == CMD_RESTART)) begin
          state_d  = ST_RSTSEQ;
          cyc_clr  = 1'b1;
          done_d   = 1'b0;
          bp_hit_d = 1'b0;
        end else if (bp_match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else if (HALT_INST) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (cmd_fire && (cmd == CMD_HALT)) begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        cpu_ce  = 1'b1;
        state_d = ST_HALTED;
        if (HALT_INST) done_d = 1'b1;
      end
      default: state_d = ST_RSTSEQ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_RSTSEQ;
      skip_q   <= 1'b0;
      bp_hit_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      bp_hit_q <= bp_hit_d;
      done_q   <= done_d;
    end
  end

  // Counts clocks spent in the reset sequence; zeroed whenever outside it.
  sat_counter #(.W(RST_W)) u_rst_cnt (
    .clk (CLK),
    .rst (RESET),
    .en  (state_q == ST_RSTSEQ),
    .clr (state_q != ST_RSTSEQ),
    .q   (rst_cnt)
  );

  sat_counter #(.W(CYC_W)) u_cyc_cnt (
    .clk (CLK),
    .rst (RESET),
    .en  (cpu_ce && (state_q != ST_RSTSEQ)),
    .clr (cyc_clr),
    .q   (cyc_cnt)
  );

  assign CMD_READY = cmd_ready;
  assign CPU_CE    = cpu_ce;
  assign CPU_RST   = (state_q == ST_RSTSEQ);
  assign EN_L      = (state_q != ST_RSTSEQ);
  assign STATE     = state_q;
  assign CYC_CNT   = cyc_cnt;
  assign BP_HIT    = bp_hit_q;
  assign DONE      = done_q;

endmodule
